sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO, the general-purpose successor to the team's dual-clock byte FIFO, for buffering between blocks that share one clock domain. It adds configurable width and depth, an occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. First-word-fall-through read mode is selectable at compile time.

---
 rtl/sync_fifo_param.sv | 99 +++++++++
 tb/tb_sync_fifo_param.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; otherwise dout is registered on each accepted read.
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        din,
  input  logic                     rd_en,
  input  logic                     clr_err,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C   = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C   = CNT_W'(AE_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              wr_acc;
  logic              rd_acc;
  logic [CNT_W-1:0]  count_next;

  // Acceptance looks only at registered flags, so a same-cycle read never frees room for a write.
  assign wr_acc     = wr_en && !full;
  assign rd_acc     = rd_en && !empty;
  assign count_next = count + CNT_W'(wr_acc) - CNT_W'(rd_acc);

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count        <= count_next;
      full         <= (count_next == FULL_C);
      empty        <= (count_next == '0);
      almost_full  <= (count_next >= AF_C);
      almost_empty <= (count_next <= AE_C);
      // A fresh error in the clearing cycle takes priority over clr_err.
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is visible whenever the FIFO holds data; zero when empty so stale words never leak.
  assign dout = empty ? '0 : mem[rd_ptr];
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
    end else if (rd_acc) begin
      dout <= mem[rd_ptr];
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param (DEPTH=8, AF=6, AE=2); covers both read modes.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] din;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] dout;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;

  int checks   = 0;
  int failures = 0;

  sync_fifo_param #(
    .DATA_W(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .clr_err(clr_err),
    .dout(dout), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // One clock of stimulus; outputs are sampled 1 time unit after the rising edge.
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
    wr_en = w; din = d; rd_en = r; clr_err = c;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    step(1'b1, d, 1'b0, 1'b0);
  endtask

  // Returns the word consumed by the read, in whichever read mode is built.
  task automatic pop(output logic [7:0] got);
`ifdef SYNC_FIFO_FWFT_EN
    got = dout;
    step(1'b0, 8'h00, 1'b1, 1'b0);
`else
    step(1'b0, 8'h00, 1'b1, 1'b0);
    got = dout;
`endif
  endtask

  task automatic push_pop(input logic [7:0] d, output logic [7:0] got);
`ifdef SYNC_FIFO_FWFT_EN
    got = dout;
    step(1'b1, d, 1'b1, 1'b0);
`else
    step(1'b1, d, 1'b1, 1'b0);
    got = dout;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b1; din = 8'h5A; rd_en = 1'b0; clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (almost_empty !== 1'b1) begin failures++; $display("FAIL reset_almost_empty got=%b exp=1", almost_empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (almost_full !== 1'b0) begin failures++; $display("FAIL reset_almost_full got=%b exp=0", almost_full); end
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", dout); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL reset_underflow got=%b exp=0", underflow); end
    rst = 1'b0; wr_en = 1'b0;
  endtask

  task automatic test_fill_drain();
    logic [7:0] got;
    for (int i = 1; i <= 8; i++) begin
      push(8'(i * 8'h11));
      checks++; if (count !== 4'(i)) begin failures++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i); end
      checks++; if (almost_empty !== (i <= 2)) begin failures++; $display("FAIL fill_almost_empty[%0d] got=%b exp=%b", i, almost_empty, i <= 2); end
      checks++; if (almost_full !== (i >= 6)) begin failures++; $display("FAIL fill_almost_full[%0d] got=%b exp=%b", i, almost_full, i >= 6); end
      checks++; if (full !== (i == 8)) begin failures++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, i == 8); end
    end
    push(8'h99);
    checks++; if (count !== 4'd8) begin failures++; $display("FAIL overflow_count got=%0d exp=8", count); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL overflow_set got=%b exp=1", overflow); end
    for (int i = 1; i <= 8; i++) begin
      pop(got);
      checks++; if (got !== 8'(i * 8'h11)) begin failures++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, got, 8'(i * 8'h11)); end
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b exp=1", empty); end
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL drain_underflow got=%b exp=0", underflow); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL overflow_sticky got=%b exp=1", overflow); end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL overflow_clear got=%b exp=0", overflow); end
  endtask

  task automatic test_wrap();
    logic [7:0] got;
    for (int i = 0; i < 5; i++) push(8'(8'h20 + i));
    for (int i = 0; i < 5; i++) begin
      pop(got);
      checks++; if (got !== 8'(8'h20 + i)) begin failures++; $display("FAIL wrap_pre[%0d] got=%h exp=%h", i, got, 8'(8'h20 + i)); end
    end
    for (int i = 0; i < 8; i++) push(8'(8'hA0 + i));
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL wrap_full got=%b exp=1", full); end
    for (int i = 0; i < 8; i++) begin
      pop(got);
      checks++; if (got !== 8'(8'hA0 + i)) begin failures++; $display("FAIL wrap_data[%0d] got=%h exp=%h", i, got, 8'(8'hA0 + i)); end
    end
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL wrap_count got=%0d exp=0", count); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got;
    push(8'h31); push(8'h32); push(8'h33);
    push_pop(8'h34, got);
    checks++; if (count !== 4'd3) begin failures++; $display("FAIL simul_mid_count got=%0d exp=3", count); end
    checks++; if (got !== 8'h31) begin failures++; $display("FAIL simul_mid_data got=%h exp=31", got); end
    for (int i = 0; i < 3; i++) begin
      pop(got);
      checks++; if (got !== 8'(8'h32 + i)) begin failures++; $display("FAIL simul_order[%0d] got=%h exp=%h", i, got, 8'(8'h32 + i)); end
    end
    for (int i = 0; i < 8; i++) push(8'(8'h40 + i));
    push_pop(8'h48, got);
    checks++; if (count !== 4'd7) begin failures++; $display("FAIL simul_full_count got=%0d exp=7", count); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL simul_full_overflow got=%b exp=1", overflow); end
    checks++; if (got !== 8'h40) begin failures++; $display("FAIL simul_full_data got=%h exp=40", got); end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 1; i < 8; i++) begin
      pop(got);
      checks++; if (got !== 8'(8'h40 + i)) begin failures++; $display("FAIL simul_full_drain[%0d] got=%h exp=%h", i, got, 8'(8'h40 + i)); end
    end
    push_pop(8'h50, got);
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL simul_empty_count got=%0d exp=1", count); end
    checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL simul_empty_underflow got=%b exp=1", underflow); end
    pop(got);
    checks++; if (got !== 8'h50) begin failures++; $display("FAIL simul_empty_data got=%h exp=50", got); end
    step(1'b0, 8'h00, 1'b1, 1'b1);
    checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL clr_vs_set got=%b exp=1", underflow); end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL underflow_clear got=%b exp=0", underflow); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) push(8'(8'h61 + i));
    checks++; if (count !== 4'd5) begin failures++; $display("FAIL midrst_pre_count got=%0d exp=5", count); end
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL midrst_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL midrst_empty got=%b exp=1", empty); end
    checks++; if (almost_empty !== 1'b1) begin failures++; $display("FAIL midrst_almost_empty got=%b exp=1", almost_empty); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL midrst_underflow got=%b exp=1", underflow); end
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL midrst_stale got=%h exp=00", dout); end
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL midrst_post_count got=%0d exp=0", count); end
    step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_read_mode();
`ifdef SYNC_FIFO_FWFT_EN
    push(8'hA5);
    checks++; if (empty !== 1'b0) begin failures++; $display("FAIL fwft_empty got=%b exp=0", empty); end
    checks++; if (dout !== 8'hA5) begin failures++; $display("FAIL fwft_head got=%h exp=a5", dout); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL fwft_pop_empty got=%b exp=1", empty); end
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL fwft_pop_dout got=%h exp=00", dout); end
`else
    push(8'hB6);
    checks++; if (empty !== 1'b0) begin failures++; $display("FAIL std_empty got=%b exp=0", empty); end
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL std_no_early got=%h exp=00", dout); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (dout !== 8'hB6) begin failures++; $display("FAIL std_read got=%h exp=b6", dout); end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (dout !== 8'hB6) begin failures++; $display("FAIL std_hold got=%h exp=b6", dout); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL std_post_empty got=%b exp=1", empty); end
`endif
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; din = 8'h00; rd_en = 1'b0; clr_err = 1'b0;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_back_to_back();
    test_mid_reset();
    test_read_mode();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
